// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Debounces NKEYS independent active-low mechanical key inputs. Each raw pin
// is first brought into the clock domain through a two-flop synchronizer.
// A per-channel counter then requires DEBOUNCE_CYCLES consecutive cycles of
// disagreement between the synchronized level and the accepted level before
// the accepted level flips. Accepted edges produce single-cycle press/release
// pulses. A press also sets a sticky event flag, which software clears by
// writing 1 to it. The interrupt line is the OR of all sticky flags.
//
// Ports
//   clock        in   system clock, rising-edge only
//   reset        in   synchronous active-high reset
//   key_n_i      in   [NKEYS] raw asynchronous key pins, 0 = pressed
//   event_clr_i  in   [NKEYS] write-1-to-clear strobes for event_o
//   key_o        out  [NKEYS] debounced level, 1 = pressed
//   press_o      out  [NKEYS] one-cycle pulse per accepted press
//   release_o    out  [NKEYS] one-cycle pulse per accepted release
//   event_o      out  [NKEYS] sticky press flags
//   irq_o        out  OR of all event_o bits
//
// Latency from a clean pin edge to key_o is DEBOUNCE_CYCLES + 2 cycles:
// two synchronizer stages followed by DEBOUNCE_CYCLES mismatching cycles.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int NKEYS           = 2,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n_i,
  input  logic [NKEYS-1:0] event_clr_i,
  output logic [NKEYS-1:0] key_o,
  output logic [NKEYS-1:0] press_o,
  output logic [NKEYS-1:0] release_o,
  output logic [NKEYS-1:0] event_o,
  output logic             irq_o
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2(N)) bits suffice.
  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NKEYS-1:0] sync1_q, sync1_d;
  logic [NKEYS-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q [NKEYS];
  logic [CNT_W-1:0] cnt_d [NKEYS];
  logic [NKEYS-1:0] key_q, key_d;
  logic [NKEYS-1:0] press_q, press_d;
  logic [NKEYS-1:0] release_q, release_d;
  logic [NKEYS-1:0] event_q, event_d;

  // Sampled level: synchronized pin, inverted to active-high.
  logic [NKEYS-1:0] s;
  assign s = ~sync2_q;

  // Next-state logic for every channel. A channel whose sampled level agrees
  // with its accepted level holds its counter at zero, so any single-cycle
  // return to the accepted level throws away all accumulated credit. When the
  // counter has already seen DEBOUNCE_CYCLES-1 mismatches, the current
  // mismatch is the last one needed: the level flips and the counter clears
  // instead of incrementing, so it can never pass CNT_MAX or wrap.
  always_comb begin
    sync1_d   = key_n_i;
    sync2_d   = sync1_q;
    key_d     = key_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < NKEYS; k++) begin
      cnt_d[k] = '0;
      if (s[k] != key_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          key_d[k]     = s[k];
          press_d[k]   = s[k];
          release_d[k] = ~s[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
    // Set wins over clear so a press landing on a clear strobe is kept.
    event_d = (event_q & ~event_clr_i) | press_d;
  end

  // All state is registered here. Synchronizers reset to 1 (released pins)
  // so that a key held down through reset is seen as a fresh press once
  // reset is removed and goes through the full debounce interval.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      key_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      event_q   <= '0;
      for (int k = 0; k < NKEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      key_q     <= key_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      for (int k = 0; k < NKEYS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign key_o     = key_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign event_o   = event_q;
  assign irq_o     = |event_q;

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter NKEYS, default 2, giving the number of independent key channels (range 1..8).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 240000 (10 ms at 24 MHz wb_clk), giving the consecutive stable cycles required before accepting a change (range 2..2^24).
REQ-003 clock  input  1  system clock; all state SHALL be updated on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n_i  input  NKEYS  raw asynchronous key pins, active-low (0 = pressed).
REQ-006 key_o  output  NKEYS  debounced key level, active-high (1 = pressed).
REQ-007 press_o  output  NKEYS  single-cycle pulse per accepted press.
REQ-008 release_o  output  NKEYS  single-cycle pulse per accepted release.
REQ-009 event_o  output  NKEYS  sticky press flags.
REQ-010 event_clr_i  input  NKEYS  write-1-to-clear strobes for event_o.
REQ-011 irq_o  output  1  OR of all event_o bits.

Function
REQ-012 Each key_n_i bit SHALL pass through a 2-flop synchronizer; the inverted second-stage output is the sampled level s[k].
REQ-013 Each channel SHALL hold a counter of width ceil(log2(DEBOUNCE_CYCLES)) bits plus a stable state bit key_o[k].
REQ-014 When s[k] equals key_o[k], the counter SHALL be cleared to 0 on that edge.
REQ-015 When s[k] differs from key_o[k] and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When s[k] differs from key_o[k] and the counter equals DEBOUNCE_CYCLES-1, key_o[k] SHALL toggle to s[k] and the counter SHALL clear to 0.
REQ-017 A change on s[k] SHALL therefore reach key_o[k] after exactly DEBOUNCE_CYCLES consecutive mismatching cycles.
REQ-018 Total latency from a clean key_n_i edge to key_o SHALL be DEBOUNCE_CYCLES+2 cycles.
REQ-019 Any single-cycle return of s[k] to key_o[k] SHALL restart the count from 0; no partial credit is retained.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-021 press_o[k] SHALL be registered and high for exactly the first cycle in which key_o[k] reads 1 after reading 0.
REQ-022 release_o[k] SHALL be high for exactly the first cycle in which key_o[k] reads 0 after reading 1.
REQ-023 press_o[k] and release_o[k] SHALL never be high in the same cycle.
REQ-024 event_o[k] SHALL be set on the edge that raises press_o[k], and cleared on an edge where event_clr_i[k]=1.
REQ-025 If set and clear coincide on the same edge, event_o[k] SHALL end set, so no press is lost.
REQ-026 event_clr_i[k]=1 with event_o[k]=0 SHALL have no effect.
REQ-027 irq_o SHALL be the combinational OR of the event_o register bits.
REQ-028 Channels SHALL be fully independent; activity on one key SHALL not affect another channel's counter or outputs.

Reset
REQ-029 While reset=1, the synchronizer flops SHALL load 1 (released), counters SHALL load 0, and key_o, press_o, release_o, event_o and irq_o SHALL be 0.
REQ-030 Reset asserted mid-count SHALL discard the count, so a held key needs a full DEBOUNCE_CYCLES+2 after reset release to appear pressed.
REQ-031 A key held pressed through reset SHALL produce a press_o pulse and set event_o once accepted after reset.

Verification (DEBOUNCE_CYCLES=4, NKEYS=2)
REQ-032 Clean press: key_n_i[0] 1->0 and held -> key_o[0] rises 6 cycles later; press_o[0] high 1 cycle; event_o[0]=1; irq_o=1.
REQ-033 Bounce: key_n_i[0] low 3 cycles, high 1, low held -> key_o[0] rises 6 cycles after the final falling edge; exactly one press_o[0] pulse.
REQ-034 Glitch rejection: key_n_i[1] low for 3 cycles only -> key_o[1] stays 0; no press_o, release_o or event.
REQ-035 Clear race: event_clr_i[0]=1 on the same edge press_o[0] sets -> event_o[0]=1 afterwards; a later clear alone -> event_o[0]=0 and irq_o=0.
REQ-036 Release: a pressed key with key_n_i 0->1 -> key_o falls after 6 cycles; release_o high 1 cycle; event_o unchanged.
REQ-037 Reset mid-operation: reset pulsed at count 2 with key held low -> all outputs 0; key_o rises 6 cycles after reset deasserts, with one press_o pulse.
